// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register: STAGES slices carrying write-back control/data,
// with stall/flush, write-back mux, gated register write, occupancy and retire count.
module memwb_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int STAGES  = 1,
    parameter int OCC_W   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic                      RegWrite_i,
    input  logic                      MemtoReg_i,
    input  logic signed [XLEN-1:0]    ALUResult_i,
    input  logic signed [XLEN-1:0]    ReadData_i,
    input  logic [RADDR_W-1:0]        RDaddr_i,
    output logic                      valid_o,
    output logic                      RegWrite_o,
    output logic                      MemtoReg_o,
    output logic signed [XLEN-1:0]    ALUResult_o,
    output logic signed [XLEN-1:0]    ReadData_o,
    output logic [RADDR_W-1:0]        RDaddr_o,
    output logic signed [XLEN-1:0]    WBData_o,
    output logic                      WBwrite_o,
    output logic [OCC_W-1:0]          occ_o,
    output logic [31:0]               retired_o
);

    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("memwb_pipe: STAGES must be in 1..4");
    end
    if ((1 << OCC_W) <= STAGES) begin : g_bad_occ_w
        $error("memwb_pipe: OCC_W too narrow to hold STAGES");
    end

    logic [STAGES-1:0]  valid_q, valid_d;
    logic [STAGES-1:0]  rw_q, rw_d;
    logic [STAGES-1:0]  mtr_q, mtr_d;
    logic [XLEN-1:0]    alu_q [STAGES];
    logic [XLEN-1:0]    alu_d [STAGES];
    logic [XLEN-1:0]    rdat_q [STAGES];
    logic [XLEN-1:0]    rdat_d [STAGES];
    logic [RADDR_W-1:0] rd_q [STAGES];
    logic [RADDR_W-1:0] rd_d [STAGES];
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [31:0]        retired_q, retired_d;

    always_comb begin
        valid_d   = valid_q;
        rw_d      = rw_q;
        mtr_d     = mtr_q;
        alu_d     = alu_q;
        rdat_d    = rdat_q;
        rd_d      = rd_q;
        retired_d = retired_q;
        occ_d     = '0;

        if (flush_i) begin
            // Kill only the bits that make an entry act; data is left in place.
            valid_d = '0;
            rw_d    = '0;
        end else if (!stall_i) begin
            valid_d[0] = valid_i;
            rw_d[0]    = RegWrite_i & valid_i;
            mtr_d[0]   = MemtoReg_i & valid_i;
            alu_d[0]   = ALUResult_i;
            rdat_d[0]  = ReadData_i;
            rd_d[0]    = RDaddr_i;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                rw_d[k]    = rw_q[k-1];
                mtr_d[k]   = mtr_q[k-1];
                alu_d[k]   = alu_q[k-1];
                rdat_d[k]  = rdat_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
        end

        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end

        // The output entry commits whenever it leaves the last slice, flushed or not.
        if (valid_q[LAST] && (!stall_i || flush_i)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= '0;
            rw_q      <= '0;
            mtr_q     <= '0;
            occ_q     <= '0;
            retired_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                alu_q[k]  <= '0;
                rdat_q[k] <= '0;
                rd_q[k]   <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            mtr_q     <= mtr_d;
            occ_q     <= occ_d;
            retired_q <= retired_d;
            for (int k = 0; k < STAGES; k++) begin
                alu_q[k]  <= alu_d[k];
                rdat_q[k] <= rdat_d[k];
                rd_q[k]   <= rd_d[k];
            end
        end
    end

    assign valid_o     = valid_q[LAST];
    assign RegWrite_o  = rw_q[LAST];
    assign MemtoReg_o  = mtr_q[LAST];
    assign ALUResult_o = alu_q[LAST];
    assign ReadData_o  = rdat_q[LAST];
    assign RDaddr_o    = rd_q[LAST];
    assign WBData_o    = MemtoReg_o ? ReadData_o : ALUResult_o;
    // x0 is hard-wired zero, so a write to it is never issued.
    assign WBwrite_o   = valid_o & RegWrite_o & (RDaddr_o != '0);
    assign occ_o       = occ_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_memwb_pipe.sv
// Bench for memwb_pipe: four instances (STAGES=1..4) share one input stream and
// are checked against a queue-based reference model plus directed scenarios.
module tb_memwb_pipe;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] rdd;
        logic [4:0]  ra;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i, RegWrite_i, MemtoReg_i;
    logic [31:0] ALUResult_i, ReadData_i;
    logic [4:0]  RDaddr_i;

    logic        v_o [4];
    logic        rw_o [4];
    logic        mtr_o [4];
    logic [31:0] alu_o [4];
    logic [31:0] rdd_o [4];
    logic [4:0]  ra_o [4];
    logic [31:0] wbd_o [4];
    logic        wbw_o [4];
    logic [2:0]  occ_o [4];
    logic [31:0] ret_o [4];

    ent_t        pipe_q [4][$];
    logic [31:0] mret [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        memwb_pipe #(.XLEN(32), .RADDR_W(5), .STAGES(g + 1), .OCC_W(3)) u_dut (
            .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
            .valid_i(valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
            .ALUResult_i(ALUResult_i), .ReadData_i(ReadData_i), .RDaddr_i(RDaddr_i),
            .valid_o(v_o[g]), .RegWrite_o(rw_o[g]), .MemtoReg_o(mtr_o[g]),
            .ALUResult_o(alu_o[g]), .ReadData_o(rdd_o[g]), .RDaddr_o(ra_o[g]),
            .WBData_o(wbd_o[g]), .WBwrite_o(wbw_o[g]), .occ_o(occ_o[g]),
            .retired_o(ret_o[g])
        );
    end

    // ---------------- reference model ----------------
    task automatic mdl_reset();
        for (int d = 0; d < 4; d++) begin
            pipe_q[d].delete();
            for (int s = 0; s <= d; s++) pipe_q[d].push_back('0);
            mret[d] = 32'd0;
        end
    endtask

    // Pipeline of depth d+1 as a queue: new entries enter at the front and the
    // entry at the back is the one currently presented to write-back.
    task automatic model_edge();
        ent_t e;
        if (!rst_i) begin
            mdl_reset();
            return;
        end
        for (int d = 0; d < 4; d++) begin
            if (pipe_q[d][d].v && (!stall_i || flush_i)) mret[d] = mret[d] + 32'd1;
            if (flush_i) begin
                for (int s = 0; s <= d; s++) begin
                    e = pipe_q[d][s];
                    e.v = 1'b0;
                    e.rw = 1'b0;
                    pipe_q[d][s] = e;
                end
            end else if (!stall_i) begin
                e.v   = valid_i;
                e.rw  = RegWrite_i & valid_i;
                e.mtr = MemtoReg_i & valid_i;
                e.alu = ALUResult_i;
                e.rdd = ReadData_i;
                e.ra  = RDaddr_i;
                pipe_q[d].push_front(e);
                void'(pipe_q[d].pop_back());
            end
        end
    endtask

    function automatic logic [139:0] exp_vec(int d);
        ent_t        e;
        logic [2:0]  occ;
        logic [31:0] wbd;
        e   = pipe_q[d][d];
        occ = '0;
        for (int s = 0; s <= d; s++) occ = occ + {2'b00, pipe_q[d][s].v};
        wbd = e.mtr ? e.rdd : e.alu;
        return {e.v, e.rw, e.mtr, e.alu, e.rdd, e.ra, wbd,
                (e.v & e.rw & (e.ra != 5'd0)), occ, mret[d]};
    endfunction

    function automatic logic [139:0] obs_vec(int d);
        return {v_o[d], rw_o[d], mtr_o[d], alu_o[d], rdd_o[d], ra_o[d], wbd_o[d],
                wbw_o[d], occ_o[d], ret_o[d]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic rw, input logic mtr,
                         input logic [31:0] alu, input logic [31:0] rdd,
                         input logic [4:0] ra, input logic stall, input logic flush);
        valid_i = v; RegWrite_i = rw; MemtoReg_i = mtr;
        ALUResult_i = alu; ReadData_i = rdd; RDaddr_i = ra;
        stall_i = stall; flush_i = flush;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1, 1, 1, $urandom, $urandom, 5'd9, 0, 0);
        rst_i = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_vec(d) !== 140'd0) begin
                errors++;
                $display("FAIL reset_async s%0d obs=%h exp=0", d + 1, obs_vec(d));
            end
        end
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_vec(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL reset_held s%0d obs=%h exp=%h", d + 1, obs_vec(d), exp_vec(d));
            end
        end
        rst_i = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 1, 0, 32'h0000_0005, $urandom, 5'd3, 0, 0);
        tick();
        checks++;
        if ({v_o[0], wbd_o[0], wbw_o[0], occ_o[0]} !== {1'b1, 32'd5, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL single_out v=%b wbd=%h wbw=%b occ=%0d exp v=1 wbd=5 wbw=1 occ=1",
                     v_o[0], wbd_o[0], wbw_o[0], occ_o[0]);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (ret_o[0] !== 32'd1) begin
            errors++;
            $display("FAIL single_retired got=%0d exp=1", ret_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_tab [3];
        logic [2:0]  peak;
        rd_tab[0] = 32'hFFFF_FFF9; rd_tab[1] = 32'd8; rd_tab[2] = 32'd9;
        peak = '0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(1, 1, 1, $urandom, rd_tab[i], 5'(i + 1), 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            if (occ_o[2] > peak) peak = occ_o[2];
            checks++;
            if (i >= 2 && i <= 4) begin
                if ({v_o[2], ra_o[2], wbd_o[2]} !== {1'b1, 5'(i - 1), rd_tab[i-2]}) begin
                    errors++;
                    $display("FAIL b2b_out edge%0d v=%b ra=%0d wbd=%h exp v=1 ra=%0d wbd=%h",
                             i + 1, v_o[2], ra_o[2], wbd_o[2], i - 1, rd_tab[i-2]);
                end
            end else if (v_o[2] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_empty edge%0d v=%b exp=0", i + 1, v_o[2]);
            end
        end
        checks++;
        if (peak !== 3'd3) begin
            errors++;
            $display("FAIL b2b_peak_occ got=%0d exp=3", peak);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 0, 32'h44, 0, 5'd4, 0, 0); tick();
        drive(1, 1, 0, 32'h55, 0, 5'd5, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 32'h99, 0, 5'd9, 1, 0);
            tick();
            checks++;
            if ({v_o[1], ra_o[1], wbd_o[1], occ_o[1], ret_o[1]} !== {1'b1, 5'd4, 32'h44, 3'd2, 32'd0}) begin
                errors++;
                $display("FAIL stall_hold cyc%0d v=%b ra=%0d wbd=%h occ=%0d ret=%0d exp 1/4/44/2/0",
                         i, v_o[1], ra_o[1], wbd_o[1], occ_o[1], ret_o[1]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if ({v_o[1], ra_o[1], ret_o[1]} !== {1'b1, 5'd5, 32'd1}) begin
            errors++;
            $display("FAIL stall_drain1 v=%b ra=%0d ret=%0d exp 1/5/1", v_o[1], ra_o[1], ret_o[1]);
        end
        tick();
        checks++;
        if ({v_o[1], occ_o[1], ret_o[1]} !== {1'b0, 3'd0, 32'd2}) begin
            errors++;
            $display("FAIL stall_drain2 v=%b occ=%0d ret=%0d exp 0/0/2", v_o[1], occ_o[1], ret_o[1]);
        end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 1, 0, 32'h11, 0, 5'd1, 0, 0); tick();
        drive(1, 1, 0, 32'h22, 0, 5'd2, 0, 0); tick();
        drive(1, 1, 0, 32'h33, 0, 5'd3, 1, 1);
        tick();
        checks++;
        if ({v_o[1], occ_o[1], wbw_o[1], ret_o[1]} !== {1'b0, 3'd0, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL flush_kill v=%b occ=%0d wbw=%b ret=%0d exp 0/0/0/1",
                     v_o[1], occ_o[1], wbw_o[1], ret_o[1]);
        end
    endtask

    task automatic test_gating();
        do_reset();
        drive(0, 1, 1, 32'h77, 32'h88, 5'd7, 0, 0);
        tick();
        checks++;
        if ({rw_o[0], wbw_o[0], mtr_o[0]} !== 3'b000) begin
            errors++;
            $display("FAIL gate_invalid rw=%b wbw=%b mtr=%b exp 0/0/0", rw_o[0], wbw_o[0], mtr_o[0]);
        end
        drive(1, 1, 0, 32'h66, 0, 5'd0, 0, 0);
        tick();
        checks++;
        if ({v_o[0], rw_o[0], wbw_o[0]} !== 3'b110) begin
            errors++;
            $display("FAIL gate_x0 v=%b rw=%b wbw=%b exp 1/1/0", v_o[0], rw_o[0], wbw_o[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1'($urandom), $urandom, $urandom, 5'($urandom_range(1, 31)), 0, 0);
            tick();
        end
        #2 rst_i = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_vec(d) !== 140'd0) begin
                errors++;
                $display("FAIL async_reset s%0d obs=%h exp=0", d + 1, obs_vec(d));
            end
        end
        mdl_reset();
        #2 rst_i = 1'b1;
        drive(1, 1, 0, 32'h1234, 0, 5'd12, 0, 0);
        tick();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (obs_vec(d) !== exp_vec(d)) begin
                errors++;
                $display("FAIL reset_release s%0d obs=%h exp=%h", d + 1, obs_vec(d), exp_vec(d));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
            tick();
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (obs_vec(d) !== exp_vec(d)) begin
                    errors++;
                    $display("FAIL random cyc%0d s%0d obs=%h exp=%h", i, d + 1, obs_vec(d), exp_vec(d));
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        mdl_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_flush();
        test_gating();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
